// File: rtl/spi_master_core_pkg.sv
// Shared definitions for the mode-0 SPI initiator.
// State encodings and SPI framing constants.
package spi_master_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    // Mode 0: clock idles low, data sampled on the leading edge.
    localparam logic       SPI_CPOL  = 1'b0;
    localparam logic [3:0] LAST_HALF = 4'd15;

endpackage

// File: rtl/spi_master_tick.sv
// Half-period timer for the SPI initiator.
// Emits one tick every HALF cycles while run is high.
module spi_master_tick #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(HALF) + 1;
    localparam logic [W-1:0] TC = W'(HALF - 1);

    logic [W-1:0] cnt;

    assign tick = run && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Mode-0 SPI initiator: byte stream in, framed SPI out.
// CS stays low across bytes until a byte flagged last completes.
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       spi_clk,
    input  logic [7:0] user_in,
    input  logic       user_in_last,
    input  logic       user_in_valid,
    output logic       user_in_ready,
    output logic [7:0] user_out,
    output logic       user_out_stb,
    output logic       busy
);

    state_t     state;
    state_t     nstate;
    logic       tick;
    logic       run;
    logic       accept;
    logic       fall;
    logic       done;
    logic [3:0] bitcnt;
    logic [6:0] tx;
    logic [6:0] rx;
    logic       last_q;

    assign user_in_ready = !rst && (state == S_IDLE || state == S_WAIT);
    assign accept = user_in_valid && user_in_ready;
    assign run = (state == S_SHIFT) || (state == S_HOLD) || (state == S_GAP);
    assign fall = (state == S_SHIFT) && tick && spi_clk;
    assign done = fall && (bitcnt == LAST_HALF);
    assign busy = !spi_cs_n || (state == S_GAP);

    spi_master_tick #(
        .HALF(HALF)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (accept) nstate = S_SHIFT;
            S_SHIFT: if (done) nstate = last_q ? S_HOLD : S_WAIT;
            S_WAIT:  if (accept) nstate = S_SHIFT;
            S_HOLD:  if (tick) nstate = S_GAP;
            S_GAP:   if (tick) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_cs_n     <= 1'b1;
            spi_clk      <= SPI_CPOL;
            spi_mosi     <= 1'b0;
            user_out     <= 8'h00;
            user_out_stb <= 1'b0;
            bitcnt       <= 4'd0;
            tx           <= 7'd0;
            rx           <= 7'd0;
            last_q       <= 1'b0;
        end else begin
            user_out_stb <= 1'b0;
            spi_cs_n <= !(nstate == S_SHIFT || nstate == S_WAIT ||
                          nstate == S_HOLD);
            if (accept) begin
                tx       <= user_in[6:0];
                spi_mosi <= user_in[7];
                last_q   <= user_in_last;
                bitcnt   <= 4'd0;
                spi_clk  <= SPI_CPOL;
            end else if (state == S_SHIFT && tick) begin
                bitcnt  <= bitcnt + 4'd1;
                spi_clk <= !spi_clk;
                if (fall) begin
                    rx <= {rx[5:0], spi_miso};
                    // mosi freezes on bit0 once the byte is complete
                    if (done) begin
                        user_out     <= {rx, spi_miso};
                        user_out_stb <= 1'b1;
                    end else begin
                        spi_mosi <= tx[6];
                        tx       <= {tx[5:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (HALF=2 and HALF=1 instances).
// Loopback and a behavioural mode-0 peripheral drive miso.
module tb_spi_master_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    // HALF=2 instance
    logic       mosi2, miso2, cs_n2, spi_clk2;
    logic [7:0] user_in2 = 8'h00;
    logic       last2 = 1'b0, valid2 = 1'b0, ready2;
    logic [7:0] user_out2;
    logic       stb2, busy2;
    logic       loop = 1'b1;

    // HALF=1 instance
    logic       mosi1, cs_n1, spi_clk1;
    logic [7:0] user_in1 = 8'h00;
    logic       last1 = 1'b0, valid1 = 1'b0, ready1;
    logic [7:0] user_out1;
    logic       stb1, busy1;

    spi_master_core #(.HALF(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .spi_mosi     (mosi2),
        .spi_miso     (miso2),
        .spi_cs_n     (cs_n2),
        .spi_clk      (spi_clk2),
        .user_in      (user_in2),
        .user_in_last (last2),
        .user_in_valid(valid2),
        .user_in_ready(ready2),
        .user_out     (user_out2),
        .user_out_stb (stb2),
        .busy         (busy2)
    );

    spi_master_core #(.HALF(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .spi_mosi     (mosi1),
        .spi_miso     (mosi1),
        .spi_cs_n     (cs_n1),
        .spi_clk      (spi_clk1),
        .user_in      (user_in1),
        .user_in_last (last1),
        .user_in_valid(valid1),
        .user_in_ready(ready1),
        .user_out     (user_out1),
        .user_out_stb (stb1),
        .busy         (busy1)
    );

    // Behavioural mode-0 peripheral: always answers 0xBA.
    logic       smiso = 1'b0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_bits = 0;
    logic [7:0] q_slave[$];

    assign miso2 = loop ? mosi2 : smiso;

    always @(negedge cs_n2) begin
        s_tx   = 8'hBA;
        smiso  = s_tx[7];
        s_bits = 0;
    end

    always @(posedge spi_clk2) begin
        if (!cs_n2) begin
            s_rx = {s_rx[6:0], mosi2};
            s_bits++;
            if (s_bits == 8) begin
                q_slave.push_back(s_rx);
                s_bits = 0;
            end
        end
    end

    always @(negedge spi_clk2) begin
        if (!cs_n2) begin
            if (s_bits == 0) s_tx = 8'hBA;
            else s_tx = {s_tx[6:0], 1'b0};
            smiso = s_tx[7];
        end
    end

    int rises2 = 0;
    int cs_rises2 = 0;
    logic [7:0] q2[$];
    always @(posedge spi_clk2) rises2++;
    always @(posedge cs_n2) cs_rises2++;
    always @(negedge clk) if (stb2) q2.push_back(user_out2);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [7:0] b, input logic l, output int t);
        int k;
        k = 0;
        while (!ready2 && k < 100) begin
            step();
            k++;
        end
        chk("send_ready", ready2, 1);
        user_in2 = b;
        last2 = l;
        valid2 = 1'b1;
        t = cyc;
        step();
        valid2 = 1'b0;
        user_in2 = 8'h00;
        last2 = 1'b0;
    endtask

    task automatic wait_idle2(input int n);
        int k;
        k = 0;
        while ((busy2 || !ready2) && k < n) begin
            step();
            k++;
        end
        chk("idle2", {busy2, ready2}, 2'b01);
    endtask

    initial begin
        int t, d, first, lastl, rdy, sat, bad, acc, nacc, tog, csl;
        logic pclk;

        // Reset
        rst = 1'b1;
        step(); step(); step();
        chk("rst_ready", ready2, 0);
        chk("rst_cs", cs_n2, 1);
        chk("rst_clk", spi_clk2, 0);
        chk("rst_mosi", mosi2, 0);
        chk("rst_out", user_out2, 8'h00);
        chk("rst_stb", stb2, 0);
        chk("rst_busy", busy2, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", ready2, 1);
        chk("post_rst_cs", cs_n2, 1);

        // Loopback 0xA5, last
        loop = 1'b1;
        rises2 = 0;
        q2.delete();
        send2(8'hA5, 1'b1, t);
        chk("a5_mosi7", mosi2, 1);
        first = -1; lastl = -1; rdy = -1; sat = -1;
        for (int k = 0; k < 45; k++) begin
            d = cyc - t;
            if (!cs_n2) begin
                if (first < 0) first = d;
                lastl = d;
            end
            if (stb2) sat = d;
            if (ready2 && rdy < 0) rdy = d;
            step();
        end
        chk("a5_rises", rises2, 8);
        chk("a5_nstb", q2.size(), 1);
        chk("a5_stb_at", sat, 33);
        chk("a5_out", q2.size() > 0 ? q2[0] : 8'hxx, 8'hA5);
        chk("a5_cs_first", first, 1);
        chk("a5_cs_last", lastl, 34);
        chk("a5_ready_at", rdy, 37);

        // Peripheral model, back-to-back 0x3C / 0xC3 with valid held
        loop = 1'b0;
        rises2 = 0;
        cs_rises2 = 0;
        q2.delete();
        q_slave.delete();
        user_in2 = 8'h3C;
        last2 = 1'b0;
        valid2 = 1'b1;
        nacc = 0;
        for (int k = 0; k < 120; k++) begin
            if (nacc == 2 && !busy2) break;
            acc = int'(valid2 && ready2);
            step();
            if (acc != 0) begin
                nacc++;
                if (nacc == 1) begin
                    user_in2 = 8'hC3;
                    last2 = 1'b1;
                end else begin
                    valid2 = 1'b0;
                    user_in2 = 8'h00;
                    last2 = 1'b0;
                end
            end
        end
        chk("b2b_accepts", nacc, 2);
        chk("b2b_cs_rises", cs_rises2, 1);
        chk("b2b_rises", rises2, 16);
        chk("b2b_nslave", q_slave.size(), 2);
        chk("b2b_slave0", q_slave.size() > 0 ? q_slave[0] : 8'hxx, 8'h3C);
        chk("b2b_slave1", q_slave.size() > 1 ? q_slave[1] : 8'hxx, 8'hC3);
        chk("b2b_nmaster", q2.size(), 2);
        chk("b2b_master0", q2.size() > 0 ? q2[0] : 8'hxx, 8'hBA);
        chk("b2b_master1", q2.size() > 1 ? q2[1] : 8'hxx, 8'hBA);
        wait_idle2(20);

        // WAIT holding, then a late 0x80
        loop = 1'b1;
        q2.delete();
        send2(8'h01, 1'b0, t);
        for (int k = 0; k < 60 && !ready2; k++) step();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (cs_n2 !== 1'b0 || spi_clk2 !== 1'b0 || ready2 !== 1'b1)
                bad++;
            step();
        end
        chk("wait_hold", bad, 0);
        send2(8'h80, 1'b1, t);
        chk("wait_u1_mosi", mosi2, 1);
        chk("wait_u1_cs", cs_n2, 0);
        step();
        chk("wait_u2_clk", spi_clk2, 0);
        step();
        chk("wait_u3_clk", spi_clk2, 1);
        step(); step();
        chk("wait_u5_mosi6", mosi2, 0);
        wait_idle2(60);
        chk("wait_out", {q2.size() == 2 ? q2[0] : 8'hxx,
                         q2.size() == 2 ? q2[1] : 8'hxx}, 16'h0180);

        // Reset at the 3rd spi_clk rise
        q2.delete();
        rises2 = 0;
        send2(8'h55, 1'b1, t);
        for (int k = 0; k < 100 && rises2 < 3; k++) step();
        chk("mid_rises", rises2, 3);
        rst = 1'b1;
        step();
        chk("mid_cs", cs_n2, 1);
        chk("mid_clk", spi_clk2, 0);
        chk("mid_stb", stb2, 0);
        chk("mid_busy", busy2, 0);
        rst = 1'b0;
        #1;
        chk("mid_ready", ready2, 1);
        for (int k = 0; k < 40; k++) step();
        chk("mid_nostb", q2.size(), 0);
        send2(8'hFF, 1'b1, t);
        wait_idle2(60);
        chk("mid_ff", {q2.size() == 1 ? q2[0] : 8'hxx}, 8'hFF);

        // Valid pulsed during SHIFT and GAP
        q2.delete();
        rises2 = 0;
        send2(8'h11, 1'b1, t);
        for (int k = 0; k < 45; k++) begin
            d = cyc - t;
            valid2 = (d == 10) || (d == 35);
            user_in2 = 8'h99;
            if (d == 10) chk("pulse_shift_rdy", ready2, 0);
            if (d == 35) chk("pulse_gap", {busy2, cs_n2, ready2}, 3'b110);
            step();
        end
        valid2 = 1'b0;
        chk("pulse_nstb", q2.size(), 1);
        chk("pulse_out", q2.size() > 0 ? q2[0] : 8'hxx, 8'h11);
        chk("pulse_rises", rises2, 8);

        // HALF=1 loopback 0x5A
        user_in1 = 8'h5A;
        last1 = 1'b1;
        valid1 = 1'b1;
        t = cyc;
        step();
        valid1 = 1'b0;
        user_in1 = 8'h00;
        last1 = 1'b0;
        sat = -1; rdy = -1; lastl = -1; tog = 0; csl = 0;
        pclk = spi_clk1;
        for (int k = 0; k < 25; k++) begin
            d = cyc - t;
            if (!cs_n1) begin
                csl++;
                lastl = d;
            end
            if (d >= 2 && d <= 17 && spi_clk1 != pclk) tog++;
            pclk = spi_clk1;
            if (stb1) begin
                sat = d;
                chk("h1_out", user_out1, 8'h5A);
            end
            if (ready1 && rdy < 0 && d > 1) rdy = d;
            step();
        end
        chk("h1_toggles", tog, 16);
        chk("h1_stb_at", sat, 17);
        chk("h1_cs_cycles", csl, 17);
        chk("h1_cs_last", lastl, 17);
        chk("h1_ready_at", rdy, 19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
